// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//   Raster timing generator that feeds the pixel painter stage. It runs a
//   horizontal and a vertical counter on vga_clk and derives the monitor syncs
//   and the painter's pixel coordinates from them.
//   Coordinates are 1-based inside the active area and 0 during blanking, so
//   "x_pixel > 0" can be used downstream as an active-area test.
//
// Ports
//   vga_clk      in   1           pixel clock, the only clock
//   rst_n        in   1           asynchronous reset, ACTIVE-HIGH despite the name
//   run          in   1           1 = counters advance, 0 = freeze counters and blank
//   hsync        out  1           horizontal sync (asserted level = SYNC_POL)
//   vsync        out  1           vertical sync   (asserted level = SYNC_POL)
//   video_de     out  1           high during an active pixel
//   x_pixel      out  COOR_WIDTH  active column 1..H_ACTIVE, else 0
//   y_pixel      out  COOR_WIDTH  active row 1..V_ACTIVE, else 0
//   line_start   out  1           one-clock pulse on the first clock of each line
//   frame_start  out  1           one-clock pulse on the first clock of each frame
//
// Every output is registered: outputs after edge t+1 describe the counter
// values held at edge t.
// -----------------------------------------------------------------------------
module vga_timing_gen #(
   parameter int   COOR_WIDTH = 12,
   parameter int   H_SYNC     = 96,
   parameter int   H_BP       = 48,
   parameter int   H_ACTIVE   = 640,
   parameter int   H_FP       = 16,
   parameter int   V_SYNC     = 2,
   parameter int   V_BP       = 33,
   parameter int   V_ACTIVE   = 480,
   parameter int   V_FP       = 10,
   parameter logic SYNC_POL   = 1'b0
) (
   input  logic                  vga_clk,
   input  logic                  rst_n,
   input  logic                  run,
   output logic                  hsync,
   output logic                  vsync,
   output logic                  video_de,
   output logic [COOR_WIDTH-1:0] x_pixel,
   output logic [COOR_WIDTH-1:0] y_pixel,
   output logic                  line_start,
   output logic                  frame_start
);

   localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
   localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

   localparam logic [COOR_WIDTH-1:0] ONE        = COOR_WIDTH'(1);
   localparam logic [COOR_WIDTH-1:0] H_LAST     = COOR_WIDTH'(H_TOTAL - 1);
   localparam logic [COOR_WIDTH-1:0] H_SYNC_END = COOR_WIDTH'(H_SYNC);
   localparam logic [COOR_WIDTH-1:0] H_ACT_BEG  = COOR_WIDTH'(H_SYNC + H_BP);
   localparam logic [COOR_WIDTH-1:0] H_ACT_END  = COOR_WIDTH'(H_SYNC + H_BP + H_ACTIVE);
   localparam logic [COOR_WIDTH-1:0] V_LAST     = COOR_WIDTH'(V_TOTAL - 1);
   localparam logic [COOR_WIDTH-1:0] V_SYNC_END = COOR_WIDTH'(V_SYNC);
   localparam logic [COOR_WIDTH-1:0] V_ACT_BEG  = COOR_WIDTH'(V_SYNC + V_BP);
   localparam logic [COOR_WIDTH-1:0] V_ACT_END  = COOR_WIDTH'(V_SYNC + V_BP + V_ACTIVE);

   // Maps a raw counter value to a 1-based coordinate inside the active area.
   function automatic logic [COOR_WIDTH-1:0] active_coord(
      input logic [COOR_WIDTH-1:0] cnt,
      input logic [COOR_WIDTH-1:0] base
   );
      return cnt - base + ONE;
   endfunction

   // Converts a logical "sync asserted" flag into the pin level.
   function automatic logic sync_level(input logic asserted);
      return asserted ? SYNC_POL : ~SYNC_POL;
   endfunction

   logic [COOR_WIDTH-1:0] h_cnt_p0;
   logic [COOR_WIDTH-1:0] v_cnt_p0;
   logic [COOR_WIDTH-1:0] h_cnt_nxt;
   logic [COOR_WIDTH-1:0] v_cnt_nxt;
   logic                  vld_p0;

   logic h_sync_i;
   logic h_act_i;
   logic v_sync_i;
   logic v_act_i;
   logic de_i;

   logic                  hsync_p1;
   logic                  vsync_p1;
   logic                  video_de_p1;
   logic [COOR_WIDTH-1:0] x_pixel_p1;
   logic [COOR_WIDTH-1:0] y_pixel_p1;
   logic                  line_start_p1;
   logic                  frame_start_p1;

   // ---- stage p0: raster counters -------------------------------------------
   assign vld_p0 = run;

   always_comb begin
      h_cnt_nxt = h_cnt_p0;
      v_cnt_nxt = v_cnt_p0;
      if (vld_p0) begin
         if (h_cnt_p0 == H_LAST) begin
            h_cnt_nxt = '0;
            v_cnt_nxt = (v_cnt_p0 == V_LAST) ? '0 : v_cnt_p0 + ONE;
         end else begin
            h_cnt_nxt = h_cnt_p0 + ONE;
         end
      end
   end

   always_ff @(posedge vga_clk or posedge rst_n) begin
      if (rst_n) begin
         h_cnt_p0 <= '0;
         v_cnt_p0 <= '0;
      end else begin
         h_cnt_p0 <= h_cnt_nxt;
         v_cnt_p0 <= v_cnt_nxt;
      end
   end

   assign h_sync_i = (h_cnt_p0 < H_SYNC_END);
   assign h_act_i  = (h_cnt_p0 >= H_ACT_BEG) && (h_cnt_p0 < H_ACT_END);
   assign v_sync_i = (v_cnt_p0 < V_SYNC_END);
   assign v_act_i  = (v_cnt_p0 >= V_ACT_BEG) && (v_cnt_p0 < V_ACT_END);
   assign de_i     = vld_p0 && h_act_i && v_act_i;

   // ---- stage p1: registered outputs ----------------------------------------
   // With run low every output is forced to its idle value while the counters
   // hold, so a paused generator looks like blanking to the monitor.
   always_ff @(posedge vga_clk or posedge rst_n) begin
      if (rst_n) begin
         hsync_p1       <= ~SYNC_POL;
         vsync_p1       <= ~SYNC_POL;
         video_de_p1    <= 1'b0;
         x_pixel_p1     <= '0;
         y_pixel_p1     <= '0;
         line_start_p1  <= 1'b0;
         frame_start_p1 <= 1'b0;
      end else begin
         hsync_p1       <= sync_level(vld_p0 && h_sync_i);
         vsync_p1       <= sync_level(vld_p0 && v_sync_i);
         video_de_p1    <= de_i;
         x_pixel_p1     <= de_i ? active_coord(h_cnt_p0, H_ACT_BEG) : '0;
         y_pixel_p1     <= de_i ? active_coord(v_cnt_p0, V_ACT_BEG) : '0;
         line_start_p1  <= vld_p0 && (h_cnt_p0 == '0);
         frame_start_p1 <= vld_p0 && (h_cnt_p0 == '0) && (v_cnt_p0 == '0);
      end
   end

   assign hsync       = hsync_p1;
   assign vsync       = vsync_p1;
   assign video_de    = video_de_p1;
   assign x_pixel     = x_pixel_p1;
   assign y_pixel     = y_pixel_p1;
   assign line_start  = line_start_p1;
   assign frame_start = frame_start_p1;

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
//   Bench for vga_timing_gen. A default-geometry instance checks the standard
//   640x480 line/frame structure; a tiny-geometry instance with active-high
//   syncs wraps frames quickly so whole-frame behaviour is also exercised.
//   A per-clock reference model derives the expected outputs from raster
//   position arithmetic.
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;

   localparam int CW = 12;
   localparam int SHS = 4, SHB = 3, SHA = 10, SHF = 2;
   localparam int SVS = 2, SVB = 3, SVA = 5, SVF = 1;
   localparam int S_FRAME = (SHS + SHB + SHA + SHF) * (SVS + SVB + SVA + SVF);

   logic          vga_clk = 1'b0;
   logic          rst_n   = 1'b0;
   logic          run     = 1'b1;

   logic          hsync, vsync, video_de, line_start, frame_start;
   logic [CW-1:0] x_pixel, y_pixel;
   logic          hsync_s, vsync_s, video_de_s, line_start_s, frame_start_s;
   logic [CW-1:0] x_pixel_s, y_pixel_s;

   vga_timing_gen dut (
      .vga_clk(vga_clk), .rst_n(rst_n), .run(run),
      .hsync(hsync), .vsync(vsync), .video_de(video_de),
      .x_pixel(x_pixel), .y_pixel(y_pixel),
      .line_start(line_start), .frame_start(frame_start)
   );

   vga_timing_gen #(
      .COOR_WIDTH(CW), .H_SYNC(SHS), .H_BP(SHB), .H_ACTIVE(SHA), .H_FP(SHF),
      .V_SYNC(SVS), .V_BP(SVB), .V_ACTIVE(SVA), .V_FP(SVF), .SYNC_POL(1'b1)
   ) dut_s (
      .vga_clk(vga_clk), .rst_n(rst_n), .run(run),
      .hsync(hsync_s), .vsync(vsync_s), .video_de(video_de_s),
      .x_pixel(x_pixel_s), .y_pixel(y_pixel_s),
      .line_start(line_start_s), .frame_start(frame_start_s)
   );

   always #5 vga_clk = ~vga_clk;

   // geometry table: index 0 = default instance, 1 = small instance
   int g_hs [2] = '{96, SHS};
   int g_hb [2] = '{48, SHB};
   int g_ha [2] = '{640, SHA};
   int g_hf [2] = '{16, SHF};
   int g_vs [2] = '{2, SVS};
   int g_vb [2] = '{33, SVB};
   int g_va [2] = '{480, SVA};
   int g_vf [2] = '{10, SVF};
   int g_pol[2] = '{0, 1};

   int mh[2], mv[2];
   int e_hs[2], e_vs[2], e_de[2], e_x[2], e_y[2], e_ls[2], e_fs[2];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int run_edges = 0;

   bit meas_s  = 1'b0;
   int last_fs = -1;
   int s_de    = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         mh[i] = 0; mv[i] = 0;
         e_hs[i] = 1 - g_pol[i]; e_vs[i] = 1 - g_pol[i];
         e_de[i] = 0; e_x[i] = 0; e_y[i] = 0; e_ls[i] = 0; e_fs[i] = 0;
      end
   endtask

   // One active clock edge of the raster: outputs describe the position
   // before the edge, then the position advances if running.
   task automatic model_edge();
      for (int i = 0; i < 2; i++) begin
         int ht, vt, hx0, vy0;
         bit in_h, in_v;
         ht  = g_hs[i] + g_hb[i] + g_ha[i] + g_hf[i];
         vt  = g_vs[i] + g_vb[i] + g_va[i] + g_vf[i];
         hx0 = g_hs[i] + g_hb[i];
         vy0 = g_vs[i] + g_vb[i];
         if (run) begin
            in_h    = (mh[i] >= hx0) && (mh[i] < hx0 + g_ha[i]);
            in_v    = (mv[i] >= vy0) && (mv[i] < vy0 + g_va[i]);
            e_hs[i] = (mh[i] < g_hs[i]) ? g_pol[i] : 1 - g_pol[i];
            e_vs[i] = (mv[i] < g_vs[i]) ? g_pol[i] : 1 - g_pol[i];
            e_de[i] = (in_h && in_v) ? 1 : 0;
            e_x[i]  = e_de[i] ? mh[i] - hx0 + 1 : 0;
            e_y[i]  = e_de[i] ? mv[i] - vy0 + 1 : 0;
            e_ls[i] = (mh[i] == 0) ? 1 : 0;
            e_fs[i] = (mh[i] == 0 && mv[i] == 0) ? 1 : 0;
            mh[i]++;
            if (mh[i] == ht) begin
               mh[i] = 0;
               mv[i] = (mv[i] + 1) % vt;
            end
         end else begin
            e_hs[i] = 1 - g_pol[i]; e_vs[i] = 1 - g_pol[i];
            e_de[i] = 0; e_x[i] = 0; e_y[i] = 0; e_ls[i] = 0; e_fs[i] = 0;
         end
      end
   endtask

   task automatic check_all();
      chk("hsync",         hsync,         e_hs[0]);
      chk("vsync",         vsync,         e_vs[0]);
      chk("video_de",      video_de,      e_de[0]);
      chk("x_pixel",       x_pixel,       e_x[0]);
      chk("y_pixel",       y_pixel,       e_y[0]);
      chk("line_start",    line_start,    e_ls[0]);
      chk("frame_start",   frame_start,   e_fs[0]);
      chk("s_hsync",       hsync_s,       e_hs[1]);
      chk("s_vsync",       vsync_s,       e_vs[1]);
      chk("s_video_de",    video_de_s,    e_de[1]);
      chk("s_x_pixel",     x_pixel_s,     e_x[1]);
      chk("s_y_pixel",     y_pixel_s,     e_y[1]);
      chk("s_line_start",  line_start_s,  e_ls[1]);
      chk("s_frame_start", frame_start_s, e_fs[1]);
   endtask

   task automatic tick();
      if (run && !rst_n) run_edges++;
      @(posedge vga_clk);
      if (!rst_n) model_edge();
      #1;
      cyc++;
      check_all();
      if (meas_s) begin
         if (frame_start_s) begin
            if (last_fs >= 0) begin
               chk("s_frame_period", cyc - last_fs, S_FRAME);
               chk("s_de_per_frame", s_de, SHA * SVA);
            end
            last_fs = cyc;
            s_de    = 0;
         end
         if (video_de_s) s_de++;
      end
   endtask

   task automatic pulse_reset();
      rst_n = 1'b1;
      #1;
      model_reset();
      check_all();
      #2;
      rst_n = 1'b0;
   endtask

   initial begin
      int vs_low, hs_low0, lines, de_cnt, first_de, last_de, x_first, y_first, x_last;
      int base;
      bit found;

      // reset held, outputs at idle values
      model_reset();
      #2 rst_n = 1'b1;
      #1;
      check_all();
      repeat (3) tick();
      rst_n = 1'b0;

      // first edge after release: frame and line start together
      tick();
      chk("first_fs", frame_start, 1);
      chk("first_ls", line_start, 1);
      chk("first_hsync", hsync, 0);
      chk("first_vsync", vsync, 0);
      meas_s = 1'b1;

      // lines 0..34: sync widths and line period
      vs_low  = (vsync == 1'b0) ? 1 : 0;
      hs_low0 = (hsync == 1'b0) ? 1 : 0;
      lines   = 0;
      for (int n = 1; n < 35 * 800; n++) begin
         tick();
         if (vsync == 1'b0) vs_low++;
         if (n < 800 && hsync == 1'b0) hs_low0++;
         if (line_start) begin
            lines++;
            chk("line_period", n % 800, 0);
         end
      end
      chk("vsync_low_clks", vs_low, 1600);
      chk("hsync_low_clks", hs_low0, 96);
      chk("lines_seen", lines, 34);

      // line 35: first active line
      de_cnt = 0; first_de = -1; last_de = -1; x_first = 0; y_first = 0; x_last = 0;
      for (int k = 0; k < 800; k++) begin
         tick();
         if (k == 0) chk("line35_start", line_start, 1);
         if (video_de) begin
            de_cnt++;
            if (first_de < 0) begin
               first_de = k; x_first = x_pixel; y_first = y_pixel;
            end
            last_de = k; x_last = x_pixel;
         end
      end
      chk("de_clks", de_cnt, 640);
      chk("de_offset", first_de, 144);
      chk("de_contiguous", last_de - first_de + 1, 640);
      chk("x_first", x_first, 1);
      chk("y_first", y_first, 1);
      chk("x_last", x_last, 640);

      // pause at x_pixel=200
      meas_s = 1'b0;
      base   = run_edges;
      found  = 1'b0;
      for (int k = 0; k < 1000 && !found; k++) begin
         tick();
         if (k == 0) begin
            chk("line36_start", line_start, 1);
            base = run_edges;
         end
         if (x_pixel == CW'(200)) found = 1'b1;
      end
      chk("wait_x200", found, 1);
      run = 1'b0;
      for (int k = 0; k < 50; k++) begin
         tick();
         chk("pause_de", video_de, 0);
      end
      run = 1'b1;
      tick();
      chk("resume_x", x_pixel, 201);
      found = 1'b0;
      for (int k = 0; k < 1000 && !found; k++) begin
         tick();
         if (line_start) found = 1'b1;
      end
      chk("wait_line37", found, 1);
      chk("counted_line_len", run_edges - base, 800);

      // asynchronous reset in the middle of a line
      found = 1'b0;
      for (int k = 0; k < 1000 && !found; k++) begin
         tick();
         if (mh[0] == 300) found = 1'b1;
      end
      chk("wait_h300", found, 1);
      pulse_reset();
      chk("mid_rst_de", video_de, 0);
      chk("mid_rst_hsync", hsync, 1);
      tick();
      chk("restart_fs", frame_start, 1);
      chk("restart_x", x_pixel, 0);

      // randomized run gaps and occasional resets
      for (int k = 0; k < 4000; k++) begin
         run = ($urandom_range(3, 0) != 0);
         if ($urandom_range(499, 0) == 0) pulse_reset();
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
